// File: rtl/load_sequencer.sv
// Load sequencer: issues word-aligned memory reads, lane-shifts the returned word and registers
// the extended result. Define MISALIGN_TRAP_EN to fault misaligned LH/LHU/LW instead of issuing.
module load_sequencer #(
  parameter int unsigned AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [2:0]    ld_funct3,
  input  logic [AW-1:0] ld_addr,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata,
  output logic [31:0]   ext_din,
  output logic [2:0]    ext_ctrl,
  input  logic [31:0]   ext_dout,
  output logic          rd_valid,
  output logic [31:0]   rd_data,
  output logic          fault,
  output logic          busy
);

  typedef enum logic [2:0] {StIdle, StReq, StExt, StDone, StFault} state_e;

  state_e        state_q, state_d;
  logic [2:0]    f3_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   ext_din_q;
  logic [2:0]    ext_ctrl_q;
  logic [31:0]   rd_data_q;
  logic          legal;
  logic          misaligned;

  function automatic logic is_legal(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  function automatic logic [2:0] ctrl_of(input logic [2:0] f3);
    logic [2:0] c;
    c = 3'b000;
    case (f3)
      3'b000:  c = 3'b100;
      3'b001:  c = 3'b010;
      3'b100:  c = 3'b011;
      3'b101:  c = 3'b001;
      default: c = 3'b000;
    endcase
    return c;
  endfunction

  always_comb begin
    legal = is_legal(ld_funct3);
`ifdef MISALIGN_TRAP_EN
    misaligned = (((ld_funct3 == 3'b001) || (ld_funct3 == 3'b101)) && ld_addr[0]) ||
                 ((ld_funct3 == 3'b010) && (ld_addr[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (ld_valid) state_d = (legal && !misaligned) ? StReq : StFault;
      StReq:   if (mem_ack) state_d = StExt;
      StExt:   state_d = StDone;
      StDone:  state_d = StIdle;
      StFault: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath: ext_din/ext_ctrl load on the ack so they are valid throughout EXT and hold after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_q       <= 3'b000;
      addr_q     <= '0;
      ext_din_q  <= 32'h0;
      ext_ctrl_q <= 3'b000;
      rd_data_q  <= 32'h0;
    end else begin
      if (state_q == StIdle && ld_valid) begin
        f3_q   <= ld_funct3;
        addr_q <= ld_addr;
      end
      if (state_q == StReq && mem_ack) begin
        ext_din_q  <= mem_rdata >> {addr_q[1:0], 3'b000};
        ext_ctrl_q <= ctrl_of(f3_q);
      end
      if (state_q == StExt) rd_data_q <= ext_dout;
    end
  end

  // Outputs
  always_comb begin
    ld_ready = (state_q == StIdle);
    busy     = (state_q != StIdle);
    mem_req  = (state_q == StReq);
    rd_valid = (state_q == StDone);
    fault    = (state_q == StFault);
    mem_addr = {addr_q[AW-1:2], 2'b00};
    ext_din  = ext_din_q;
    ext_ctrl = ext_ctrl_q;
    rd_data  = rd_data_q;
  end

endmodule
